pc_trap_unit: RTL and testbench

PC_TRAP_UNIT -- requirements
Module: pc_trap_unit

---
 rtl/pc_trap_unit.sv | 132 +++++++++++++
 tb/tb_pc_trap_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_trap_unit.sv
// Program counter with conditional branch, jal/jalr, memory stall and a
// single-level interrupt handler (trap vector, saved return PC, trap counter).
module pc_trap_unit #(
    parameter int                NBITS    = 8,
    parameter logic [NBITS-1:0]  RESET_PC = '0,
    parameter logic [NBITS-1:0]  TRAP_VEC = 'h80,
    parameter int                ISTEP    = 4,
    parameter int                NCNT     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Branch,
    input  logic [2:0]       funct3,
    input  logic             Zero,
    input  logic             Neg,
    input  logic             Carry,
    input  logic             ju,
    input  logic             jr,
    input  logic             sret,
    input  logic [NBITS-1:0] IMM,
    input  logic [NBITS-1:0] PCReg,
    input  logic             busy,
    input  logic             interrupt,
    output logic [NBITS-1:0] pc,
    output logic [NBITS-1:0] pc_,
    output logic [NBITS-1:0] pclink,
    output logic             link,
    output logic [NBITS-1:0] sepc,
    output logic             in_trap,
    output logic [NCNT-1:0]  trap_count
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] sepc_q, sepc_d;
    logic             pending_q, pending_d;
    logic [NCNT-1:0]  trap_count_q, trap_count_d;

    logic [NBITS-1:0] pc_plus, pc_branch, jalr_sum, jalr_t, ppc;
    logic             cond;

    assign pc_plus   = pc_q + NBITS'(ISTEP);
    assign pc_branch = pc_q + IMM;
    assign jalr_sum  = PCReg + IMM;
    assign jalr_t    = {jalr_sum[NBITS-1:1], 1'b0};

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            3'b000:  cond = Zero;
            3'b001:  cond = !Zero;
            3'b100:  cond = Neg;
            3'b101:  cond = !Neg;
            3'b110:  cond = !Carry;
            3'b111:  cond = Carry;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        if (jr)                ppc = jalr_t;
        else if (ju)           ppc = pc_branch;
        else if (Branch && cond) ppc = pc_branch;
        else                   ppc = pc_plus;
    end

    always_comb begin
        pc_d         = ppc;
        state_d      = state_q;
        sepc_d       = sepc_q;
        pending_d    = pending_q | interrupt;
        trap_count_d = trap_count_q;

        if (reset) begin
            pc_d = RESET_PC;
        end else if (busy) begin
            pc_d = pc_q;
        end else begin
            unique case (state_q)
                RUN: begin
                    // The branch/jump target of this cycle becomes the return address.
                    if (pending_q || interrupt) begin
                        pc_d      = TRAP_VEC;
                        sepc_d    = ppc;
                        state_d   = HANDLER;
                        pending_d = 1'b0;
                        if (!(&trap_count_q)) trap_count_d = trap_count_q + 1'b1;
                    end
                end
                HANDLER: begin
                    if (sret) begin
                        pc_d    = sepc_q;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            state_q      <= RUN;
            sepc_q       <= '0;
            pending_q    <= 1'b0;
            trap_count_q <= '0;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            sepc_q       <= sepc_d;
            pending_q    <= pending_d;
            trap_count_q <= trap_count_d;
        end
    end

    assign pc         = pc_q;
    assign pc_        = pc_d;
    assign pclink     = pc_plus;
    assign link       = (ju | jr) & !busy & !reset;
    assign sepc       = sepc_q;
    assign in_trap    = (state_q == HANDLER);
    assign trap_count = trap_count_q;

endmodule

// File: tb/tb_pc_trap_unit.sv
// Directed bench for pc_trap_unit: sequencing, branches, jumps, stall,
// interrupt entry/return, pending capture and reset during a handler.
module tb_pc_trap_unit;

    logic       clock = 1'b0;
    logic       reset, Branch, Zero, Neg, Carry, ju, jr, sret, busy, interrupt;
    logic [2:0] funct3;
    logic [7:0] IMM, PCReg;
    logic [7:0] pc, pc_, pclink, sepc, trap_count;
    logic       link, in_trap;

    int n_compared = 0;
    int n_mismatch = 0;

    pc_trap_unit dut (
        .clock(clock), .reset(reset), .Branch(Branch), .funct3(funct3),
        .Zero(Zero), .Neg(Neg), .Carry(Carry), .ju(ju), .jr(jr), .sret(sret),
        .IMM(IMM), .PCReg(PCReg), .busy(busy), .interrupt(interrupt),
        .pc(pc), .pc_(pc_), .pclink(pclink), .link(link), .sepc(sepc),
        .in_trap(in_trap), .trap_count(trap_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatch++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctrl();
        Branch = 0; funct3 = 3'b000; Zero = 0; Neg = 0; Carry = 0;
        ju = 0; jr = 0; sret = 0; busy = 0; interrupt = 0;
        IMM = 8'h00; PCReg = 8'h00;
    endtask

    initial begin
        clear_ctrl();
        reset = 1;
        // Controls during reset must not produce link or latch an interrupt.
        ju = 1; interrupt = 1; busy = 1;
        #1;
        check("rst_pc_next", pc_, 8'h00);
        check("rst_link", link, 1'b0);
        tick();
        check("rst_pc", pc, 8'h00);
        check("rst_in_trap", in_trap, 1'b0);
        check("rst_sepc", sepc, 8'h00);
        check("rst_count", trap_count, 8'h00);

        clear_ctrl();
        reset = 0;
        #1;
        check("seq0_pc", pc, 8'h00);
        check("seq0_pc_next", pc_, 8'h04);
        tick();
        check("seq1_pc", pc, 8'h04);
        check("seq1_pc_next", pc_, 8'h08);
        tick();
        check("seq2_pc", pc, 8'h08);
        check("seq2_pc_next", pc_, 8'h0c);

        // Branch conditions at pc=8
        Branch = 1; funct3 = 3'b000; Zero = 1; IMM = 8'hf8; #1;
        check("beq_taken", pc_, 8'h00);
        Zero = 0; #1;
        check("beq_not_taken", pc_, 8'h0c);
        funct3 = 3'b110; Carry = 0; IMM = 8'h10; #1;
        check("bgeu_taken", pc_, 8'h18);
        funct3 = 3'b010; Zero = 1; Neg = 1; Carry = 1; #1;
        check("f010_never", pc_, 8'h0c);
        funct3 = 3'b111; #1;
        check("bltu_taken", pc_, 8'h18);
        funct3 = 3'b101; Neg = 1; #1;
        check("bge_not_taken", pc_, 8'h0c);
        check("branch_no_link", link, 1'b0);
        clear_ctrl();

        // Jumps at pc=8
        jr = 1; PCReg = 8'h21; IMM = 8'h02; #1;
        check("jalr_target", pc_, 8'h22);
        check("jalr_link", link, 1'b1);
        check("jalr_pclink", pclink, 8'h0c);
        ju = 1; #1;
        check("jr_over_ju", pc_, 8'h22);
        jr = 0; #1;
        check("jal_target", pc_, 8'h0a);
        busy = 1; #1;
        check("busy_hold_pc", pc_, 8'h08);
        check("busy_no_link", link, 1'b0);
        busy = 0; IMM = 8'h08; #1;
        check("jal_to_10", pc_, 8'h10);
        tick();
        clear_ctrl();
        #1;
        check("at_10_pc", pc, 8'h10);

        // Interrupt pulse during a two-cycle stall
        busy = 1; interrupt = 1; #1;
        check("stall0_pc_next", pc_, 8'h10);
        tick();
        interrupt = 0; #1;
        check("stall1_pc", pc, 8'h10);
        check("stall1_in_trap", in_trap, 1'b0);
        tick();
        check("stall2_pc", pc, 8'h10);
        busy = 0; #1;
        check("take_pc_next", pc_, 8'h80);
        tick();
        check("h1_pc", pc, 8'h80);
        check("h1_sepc", sepc, 8'h14);
        check("h1_in_trap", in_trap, 1'b1);
        check("h1_count", trap_count, 8'h01);
        check("h1_pc_next", pc_, 8'h84);
        tick();

        // Interrupt in handler only pends; sret returns, then the trap is retaken
        interrupt = 1; #1;
        check("no_nest_pc_next", pc_, 8'h88);
        tick();
        interrupt = 0;
        check("no_nest_in_trap", in_trap, 1'b1);
        check("no_nest_count", trap_count, 8'h01);
        sret = 1; #1;
        check("sret_pc_next", pc_, 8'h14);
        tick();
        sret = 0; #1;
        check("ret_pc", pc, 8'h14);
        check("ret_in_trap", in_trap, 1'b0);
        check("retake_pc_next", pc_, 8'h80);
        tick();
        check("retake_in_trap", in_trap, 1'b1);
        check("retake_count", trap_count, 8'h02);
        check("retake_sepc", sepc, 8'h18);

        // Reset while in handler with an interrupt pending
        interrupt = 1;
        tick();
        interrupt = 0; reset = 1; busy = 1; #1;
        check("rst_h_pc_next", pc_, 8'h00);
        tick();
        reset = 0; busy = 0; #1;
        check("rst_h_pc", pc, 8'h00);
        check("rst_h_in_trap", in_trap, 1'b0);
        check("rst_h_sepc", sepc, 8'h00);
        check("rst_h_count", trap_count, 8'h00);
        check("rst_h_no_trap", pc_, 8'h04);
        tick();
        check("rst_h_still_run", in_trap, 1'b0);

        // Interrupt coincident with jal at pc=4: jump target saved, link kept
        ju = 1; IMM = 8'h20; interrupt = 1; #1;
        check("irq_jal_pc_next", pc_, 8'h80);
        check("irq_jal_link", link, 1'b1);
        check("irq_jal_pclink", pclink, 8'h08);
        tick();
        clear_ctrl();
        #1;
        check("irq_jal_sepc", sepc, 8'h24);
        check("irq_jal_count", trap_count, 8'h01);

        // sret ignored while stalled
        busy = 1; sret = 1; #1;
        check("busy_sret_pc_next", pc_, 8'h80);
        tick();
        check("busy_sret_in_trap", in_trap, 1'b1);
        busy = 0; #1;
        check("sret2_pc_next", pc_, 8'h24);
        tick();
        check("sret2_pc", pc, 8'h24);
        check("sret2_in_trap", in_trap, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
